// File: rtl/freq_meas_pkg.sv
// Shared constants and state encoding for the frequency/duty measurement block.
package freq_meas_pkg;

  // Measurement FSM states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2
  } state_e;

  localparam int unsigned CNT_W_DEF       = 16;
  localparam int unsigned SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/freq_meas_sync_edge_det.sv
// Pin-input conditioner: multi-flop synchronizer followed by a registered rising-edge
// detector. o_sig_s is delayed so that it lines up with o_rise cycle for cycle.
module freq_meas_sync_edge_det
  import freq_meas_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sig,
  output logic o_sig_s,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   r_rise;

  // Synchronize the raw input, then register the edge so the FSM sees a clean pulse
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_sig};
      r_prev <= r_sync[SYNC_STAGES-1];
      r_rise <= r_sync[SYNC_STAGES-1] & ~r_prev;
    end
  end

  // r_prev holds the synchronized level of the same sample that produced r_rise
  assign o_sig_s = r_prev;
  assign o_rise  = r_rise;

endmodule

// File: rtl/freq_meas.sv
// Measures period and high time of a slow (possibly asynchronous) input in clk cycles.
// One result per input period; a timeout pulse flags a missing rising edge.
module freq_meas
  import freq_meas_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_sig_in,
  output logic [CNT_W-1:0] o_period,
  output logic [CNT_W-1:0] o_high_time,
  output logic             o_period_valid,
  output logic             o_timeout,
  output logic             o_busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_hcnt;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_high;
  logic             r_valid;
  logic             r_timeout;
  logic             r_busy;
  logic             w_sig_s;
  logic             w_rise;

  freq_meas_sync_edge_det #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge_det (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_sig   (i_sig_in),
    .o_sig_s (w_sig_s),
    .o_rise  (w_rise)
  );

  // Measurement FSM with counters and registered result/pulse outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_hcnt    <= '0;
      r_period  <= '0;
      r_high    <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      if (!i_en) begin
        // Disable overrides everything, including a coincident rise
        r_state <= ST_IDLE;
        r_cnt   <= '0;
        r_hcnt  <= '0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state <= ST_ARM;
            r_busy  <= 1'b1;
          end
          ST_ARM: begin
            // First rise only starts the count, so the first result is a full period
            if (w_rise) begin
              r_state <= ST_MEASURE;
              r_cnt   <= CNT_ONE;
              r_hcnt  <= CNT_ONE;
            end
          end
          ST_MEASURE: begin
            if (w_rise) begin
              // Rise takes priority over a coincident timeout
              r_period <= r_cnt;
              r_high   <= r_hcnt;
              r_valid  <= 1'b1;
              r_cnt    <= CNT_ONE;
              r_hcnt   <= CNT_ONE;
            end else if (r_cnt == CNT_MAX) begin
              r_timeout <= 1'b1;
              r_cnt     <= '0;
              r_hcnt    <= '0;
              r_state   <= ST_ARM;
            end else begin
              r_cnt <= r_cnt + CNT_ONE;
              if (w_sig_s) begin
                r_hcnt <= r_hcnt + CNT_ONE;
              end
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_period       = r_period;
  assign o_high_time    = r_high;
  assign o_period_valid = r_valid;
  assign o_timeout      = r_timeout;
  assign o_busy         = r_busy;

endmodule
